// File: rtl/header_filter_if.sv
// Stream/header bundle between the payload aligner, the header filter and its consumer.
// Signal names follow the filter's documented port list; COUNT_W must match the filter instance.
interface header_filter_if #(
  parameter int COUNT_W = 32
);
  logic [47:0]        iHeader_A;
  logic               iHeader_A_valid;
  logic [47:0]        iHeader_B;
  logic               iHeader_B_valid;
  logic [15:0]        iHeader_C;
  logic               iHeader_C_valid;
  logic [63:0]        iPayload;
  logic               iPayload_valid;
  logic               iSop;
  logic               iEop;
  logic [7:0]         iByte_enable;
  logic [47:0]        iMac_addr;
  logic [15:0]        iEthertype;
  logic               iPromisc;
  logic [63:0]        oPayload;
  logic               oPayload_valid;
  logic               oSop;
  logic               oEop;
  logic [7:0]         oByte_enable;
  logic [47:0]        oHeader_B;
  logic [15:0]        oHeader_C;
  logic               oAbort;
  logic [COUNT_W-1:0] oPass_count;
  logic [COUNT_W-1:0] oDrop_count;

  modport master (
    output iHeader_A, iHeader_A_valid, iHeader_B, iHeader_B_valid,
           iHeader_C, iHeader_C_valid, iPayload, iPayload_valid,
           iSop, iEop, iByte_enable, iMac_addr, iEthertype, iPromisc,
    input  oPayload, oPayload_valid, oSop, oEop, oByte_enable,
           oHeader_B, oHeader_C, oAbort, oPass_count, oDrop_count
  );

  modport slave (
    input  iHeader_A, iHeader_A_valid, iHeader_B, iHeader_B_valid,
           iHeader_C, iHeader_C_valid, iPayload, iPayload_valid,
           iSop, iEop, iByte_enable, iMac_addr, iEthertype, iPromisc,
    output oPayload, oPayload_valid, oSop, oEop, oByte_enable,
           oHeader_B, oHeader_C, oAbort, oPass_count, oDrop_count
  );
endinterface

// File: rtl/header_filter.sv
// Accept/drop filter on destination MAC and ethertype with a one-cycle registered payload path.
// Define HEADER_FILTER_STATS_EN to build the saturating pass/drop counters; otherwise they read 0.
module header_filter #(
  parameter int COUNT_W = 32
) (
  input logic            iClk,
  input logic            iReset,
  header_filter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t      state_reg;
  logic [47:0] hold_a_reg;
  logic [47:0] hold_b_reg;
  logic [15:0] hold_c_reg;
  logic [2:0]  seen_reg;

  logic [63:0] payload_reg;
  logic        valid_reg;
  logic        sop_reg;
  logic        eop_reg;
  logic [7:0]  be_reg;
  logic        abort_reg;
  logic [47:0] out_b_reg;
  logic [15:0] out_c_reg;

  logic        sop_beat;
  logic        eop_beat;
  logic [47:0] hdr_a;
  logic [47:0] hdr_b;
  logic [15:0] hdr_c;
  logic [2:0]  seen;
  logic        accept;
  logic        forward;
  logic        truncate;

  assign sop_beat = bus.iPayload_valid & bus.iSop;
  assign eop_beat = bus.iPayload_valid & bus.iEop;

  // A header arriving on the sop beat is used directly instead of the held copy.
  assign hdr_a = bus.iHeader_A_valid ? bus.iHeader_A : hold_a_reg;
  assign hdr_b = bus.iHeader_B_valid ? bus.iHeader_B : hold_b_reg;
  assign hdr_c = bus.iHeader_C_valid ? bus.iHeader_C : hold_c_reg;
  assign seen  = seen_reg | {bus.iHeader_C_valid, bus.iHeader_B_valid, bus.iHeader_A_valid};

  assign accept = (&seen) &
                  (bus.iPromisc |
                   ((hdr_a == bus.iMac_addr) && (hdr_c == bus.iEthertype)) |
                   (hdr_a == 48'hFFFF_FFFF_FFFF));

  assign forward  = sop_beat ? accept : (bus.iPayload_valid && (state_reg == PASS));
  assign truncate = sop_beat && (state_reg == PASS);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_reg   <= IDLE;
      hold_a_reg  <= '0;
      hold_b_reg  <= '0;
      hold_c_reg  <= '0;
      seen_reg    <= '0;
      payload_reg <= '0;
      valid_reg   <= 1'b0;
      sop_reg     <= 1'b0;
      eop_reg     <= 1'b0;
      be_reg      <= '0;
      abort_reg   <= 1'b0;
      out_b_reg   <= '0;
      out_c_reg   <= '0;
    end else begin
      if (sop_beat) begin
        seen_reg <= '0;
      end else begin
        if (bus.iHeader_A_valid) begin
          hold_a_reg  <= bus.iHeader_A;
          seen_reg[0] <= 1'b1;
        end
        if (bus.iHeader_B_valid) begin
          hold_b_reg  <= bus.iHeader_B;
          seen_reg[1] <= 1'b1;
        end
        if (bus.iHeader_C_valid) begin
          hold_c_reg  <= bus.iHeader_C;
          seen_reg[2] <= 1'b1;
        end
      end

      if (sop_beat) begin
        if (eop_beat)    state_reg <= IDLE;
        else if (accept) state_reg <= PASS;
        else             state_reg <= DROP;
      end else if (eop_beat) begin
        state_reg <= IDLE;
      end

      valid_reg   <= forward;
      payload_reg <= forward ? bus.iPayload : 64'd0;
      be_reg      <= forward ? bus.iByte_enable : 8'd0;
      sop_reg     <= forward & bus.iSop;
      eop_reg     <= forward & bus.iEop;
      abort_reg   <= forward & truncate;

      // Header outputs latch with the first forwarded beat and hold until the next accept.
      if (sop_beat && accept) begin
        out_b_reg <= hdr_b;
        out_c_reg <= hdr_c;
      end
    end
  end

  assign bus.oPayload       = payload_reg;
  assign bus.oPayload_valid = valid_reg;
  assign bus.oSop           = sop_reg;
  assign bus.oEop           = eop_reg;
  assign bus.oByte_enable   = be_reg;
  assign bus.oAbort         = abort_reg;
  assign bus.oHeader_B      = out_b_reg;
  assign bus.oHeader_C      = out_c_reg;

`ifdef HEADER_FILTER_STATS_EN
  logic       pass_inc;
  logic [1:0] drop_inc;

  // A truncated pass and a rejected new packet on the same beat count as two drops.
  assign pass_inc = forward & eop_beat;
  assign drop_inc = {1'b0, sop_beat & ~accept} + {1'b0, truncate};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    logic [COUNT_W-1:0] count_reg;
    logic [1:0]         inc;
    logic [COUNT_W:0]   sum;

    assign inc = (gi == 0) ? {1'b0, pass_inc} : drop_inc;
    assign sum = {1'b0, count_reg} + {{(COUNT_W-1){1'b0}}, inc};

    always_ff @(posedge iClk) begin
      if (iReset) begin
        count_reg <= '0;
      end else begin
        count_reg <= sum[COUNT_W] ? {COUNT_W{1'b1}} : sum[COUNT_W-1:0];
      end
    end
  end

  assign bus.oPass_count = g_cnt[0].count_reg;
  assign bus.oDrop_count = g_cnt[1].count_reg;
`else
  assign bus.oPass_count = '0;
  assign bus.oDrop_count = '0;
`endif

endmodule

// File: tb/tb_header_filter.sv
// Directed bench for header_filter: a negedge monitor compares every output cycle against a queue
// of expected beats; packet-level counter checks use hand-computed totals.
module tb_header_filter;

  localparam int          CW   = 32;
  localparam logic [47:0] MAC  = 48'h0011_2233_4455;
  localparam logic [15:0] ETH  = 16'h0800;
  localparam logic [15:0] ETH6 = 16'h86DD;
  localparam logic [47:0] BC   = 48'hFFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] d;
    logic        s;
    logic        e;
    logic        ab;
    logic [7:0]  be;
    logic [47:0] hb;
    logic [15:0] hc;
    int          cyc;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    pkt_id = 0;
  int    exp_pass = 0;
  int    exp_drop = 0;
  bit    mon_on = 1'b0;
  beat_t exp_q[$];

  header_filter_if #(.COUNT_W(CW)) bus ();

  header_filter #(.COUNT_W(CW)) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int stat(input int v);
`ifdef HEADER_FILTER_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("beat_missing_at", 64'(cyc), 64'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (bus.oPayload_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(bus.oPayload), 64'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_cycle", 64'(cyc), 64'(e.cyc));
          check("beat_data", bus.oPayload, e.d);
          check("beat_sop_eop_abort", {61'd0, bus.oSop, bus.oEop, bus.oAbort}, {61'd0, e.s, e.e, e.ab});
          check("beat_be", 64'(bus.oByte_enable), 64'(e.be));
          check("hdr_b", 64'(bus.oHeader_B), 64'(e.hb));
          check("hdr_c", 64'(bus.oHeader_C), 64'(e.hc));
        end
      end else begin
        check("quiet_when_invalid",
              64'(bus.oSop | bus.oEop | bus.oAbort | (|bus.oPayload) | (|bus.oByte_enable)), 64'd0);
      end
    end
  end

  task automatic clear_hdr();
    bus.iHeader_A_valid = 1'b0;
    bus.iHeader_B_valid = 1'b0;
    bus.iHeader_C_valid = 1'b0;
  endtask

  task automatic set_hdr(input logic [47:0] a, input logic [47:0] b, input logic [15:0] c,
                         input logic [2:0] mask);
    bus.iHeader_A = a;  bus.iHeader_A_valid = mask[0];
    bus.iHeader_B = b;  bus.iHeader_B_valid = mask[1];
    bus.iHeader_C = c;  bus.iHeader_C_valid = mask[2];
  endtask

  task automatic idle_cycle();
    bus.iPayload_valid = 1'b0;
    @(posedge clk);
    #1;
    clear_hdr();
  endtask

  task automatic beat(input logic [63:0] d, input bit s, input bit e, input logic [7:0] be,
                      input bit fwd, input bit ab, input logic [47:0] hb, input logic [15:0] hc);
    bus.iPayload       = d;
    bus.iPayload_valid = 1'b1;
    bus.iSop           = s;
    bus.iEop           = e;
    bus.iByte_enable   = be;
    if (fwd) exp_q.push_back('{d: d, s: s, e: e, ab: ab, be: be, hb: hb, hc: hc, cyc: cyc + 1});
    @(posedge clk);
    #1;
    bus.iPayload_valid = 1'b0;
    bus.iSop           = 1'b0;
    bus.iEop           = 1'b0;
    clear_hdr();
  endtask

  function automatic logic [63:0] pdata(input int i);
    return {16'(pkt_id), 16'hC0DE, 32'(i)};
  endfunction

  task automatic pkt(input string name, input logic [47:0] a, input logic [47:0] b,
                     input logic [15:0] c, input logic [2:0] mask, input bit early,
                     input int n, input bit fwd);
    pkt_id++;
    if (early) begin
      set_hdr(a, b, c, mask);
      idle_cycle();
    end
    for (int i = 0; i < n; i++) begin
      if (!early && i == 0) set_hdr(a, b, c, mask);
      beat(pdata(i), i == 0, i == n - 1, (i == n - 1) ? 8'h0F : 8'hFF, fwd, 1'b0, b, c);
    end
    $display("pkt %0d %s beats=%0d forwarded=%0d", pkt_id, name, n, fwd);
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, "_pass"}, 64'(bus.oPass_count), 64'(stat(exp_pass)));
    check({tag, "_drop"}, 64'(bus.oDrop_count), 64'(stat(exp_drop)));
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) idle_cycle();
    rst = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.iPayload = '0;  bus.iPayload_valid = 1'b0;
    bus.iSop = 1'b0;    bus.iEop = 1'b0;    bus.iByte_enable = '0;
    bus.iHeader_A = '0; bus.iHeader_B = '0; bus.iHeader_C = '0;
    clear_hdr();
    bus.iMac_addr = MAC;
    bus.iEthertype = ETH;
    bus.iPromisc = 1'b0;

    // Junk presented during reset must leave no trace.
    set_hdr(MAC, 48'hAAAA, ETH, 3'b111);
    beat(64'hDEAD, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, '0, '0);
    do_reset(2);
    @(negedge clk);
    check("reset_valid", 64'(bus.oPayload_valid), 64'd0);
    check("reset_hdr_b", 64'(bus.oHeader_B), 64'd0);
    check("reset_pass", 64'(bus.oPass_count), 64'd0);
    check("reset_drop", 64'(bus.oDrop_count), 64'd0);
    mon_on = 1'b1;

    // First cycle after reset: headers on the sop beat itself.
    pkt("match_first_after_reset", MAC, 48'h0A0B_0C0D_0E0F, ETH, 3'b111, 1'b0, 5, 1'b1);
    exp_pass++;
    check_counts("match");

    pkt("ethertype_mismatch", MAC, 48'h1111, ETH6, 3'b111, 1'b1, 4, 1'b0);
    exp_drop++;
    check_counts("mismatch");

    bus.iPromisc = 1'b1;
    pkt("ethertype_mismatch_promisc", MAC, 48'h2222, ETH6, 3'b111, 1'b1, 4, 1'b1);
    bus.iPromisc = 1'b0;
    exp_pass++;
    check_counts("promisc");

    pkt("broadcast", BC, 48'h3333, ETH6, 3'b111, 1'b1, 3, 1'b1);
    exp_pass++;
    pkt("missing_c", MAC, 48'h4444, ETH, 3'b011, 1'b1, 3, 1'b0);
    exp_drop++;
    check_counts("bcast_missing");

    pkt("one_beat", MAC, 48'h5555, ETH, 3'b111, 1'b1, 1, 1'b1);
    exp_pass++;
    beat(64'h1234, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, '0, '0);
    beat(64'h5678, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, '0, '0);
    $display("stray beats in IDLE discarded");
    check_counts("one_beat_stray");

    // Station address changed mid-packet: the decision already taken stands.
    pkt_id++;
    set_hdr(MAC, 48'h6666, ETH, 3'b111);
    beat(pdata(0), 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 48'h6666, ETH);
    bus.iMac_addr = 48'h0099_8877_6655;
    beat(pdata(1), 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 48'h6666, ETH);
    beat(pdata(2), 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 48'h6666, ETH);
    bus.iMac_addr = MAC;
    exp_pass++;
    $display("pkt %0d mac_change_mid_packet forwarded=1", pkt_id);
    check_counts("mac_change");

    // Truncation: second sop on beat 3 carries the abort.
    pkt_id++;
    set_hdr(MAC, 48'h7777, ETH, 3'b111);
    beat(pdata(0), 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 48'h7777, ETH);
    beat(pdata(1), 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 48'h7777, ETH);
    set_hdr(MAC, 48'h8888, ETH, 3'b111);
    beat(pdata(2), 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1, 48'h8888, ETH);
    for (int i = 3; i < 7; i++)
      beat(pdata(i), 1'b0, i == 6, 8'hFF, 1'b1, 1'b0, 48'h8888, ETH);
    exp_drop++;
    exp_pass++;
    $display("pkt %0d truncated_then_new forwarded=1", pkt_id);
    check_counts("truncate");

    // Reset during beat 2: the rest of the packet is discarded.
    pkt_id++;
    set_hdr(MAC, 48'h9999, ETH, 3'b111);
    beat(pdata(0), 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 48'h9999, ETH);
    rst = 1'b1;
    beat(pdata(1), 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 48'h9999, ETH);
    rst = 1'b0;
    exp_pass = 0;
    exp_drop = 0;
    for (int i = 2; i < 5; i++)
      beat(pdata(i), 1'b0, i == 4, 8'hFF, 1'b0, 1'b0, 48'h9999, ETH);
    $display("pkt %0d reset_mid_packet forwarded=partial", pkt_id);
    check_counts("reset_mid");
    check("reset_mid_hdr_b", 64'(bus.oHeader_B), 64'd0);
    pkt("after_reset", MAC, 48'hABCD, ETH, 3'b111, 1'b1, 5, 1'b1);
    exp_pass++;
    check_counts("after_reset");

    // Back-to-back: 100 five-beat packets, every other one matching.
    do_reset(1);
    for (int p = 0; p < 100; p++) begin
      pkt((p % 2 == 0) ? "b2b_match" : "b2b_drop", MAC, 48'(p), (p % 2 == 0) ? ETH : ETH6,
          3'b111, 1'b0, 5, p % 2 == 0);
    end
    exp_pass = 50;
    exp_drop = 50;
    check_counts("b2b");

    repeat (3) @(negedge clk);
    check("expected_beats_left", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/header_filter.md
HEADER_FILTER -- requirements
Module: header_filter

Interface
REQ-001 Parameter COUNT_W, default 32, width of the statistics counters.
REQ-002 iClk  input  1  single clock; all logic is rising-edge.
REQ-003 iReset  input  1  synchronous, active-high reset.
REQ-004 iHeader_A / iHeader_A_valid  input  48 / 1  destination address from payload_aligner, qualified by valid.
REQ-005 iHeader_B / iHeader_B_valid  input  48 / 1  source address, qualified by valid.
REQ-006 iHeader_C / iHeader_C_valid  input  16 / 1  ethertype, qualified by valid.
REQ-007 iPayload / iPayload_valid  input  64 / 1  aligned payload beat, qualified by valid.
REQ-008 iSop, iEop  input  1 each  first and last payload beat markers, meaningful only with iPayload_valid.
REQ-009 iByte_enable  input  8  valid bytes of the current beat; bit 0 is byte 0.
REQ-010 iMac_addr  input  48  station address to accept.
REQ-011 iEthertype  input  16  ethertype to accept.
REQ-012 iPromisc  input  1  when 1, accept every complete packet regardless of header match.
REQ-013 oPayload, oPayload_valid, oSop, oEop, oByte_enable  output  64,1,1,1,8  filtered payload stream.
REQ-014 oHeader_B, oHeader_C  output  48, 16  headers of the packet currently being forwarded, stable from oSop to oEop.
REQ-015 oAbort  output  1  one-cycle pulse marking a forwarded packet truncated by a new iSop.
REQ-016 oPass_count, oDrop_count  output  COUNT_W each  accepted and rejected packet counts.

Function
REQ-017 Each header valid pulses for exactly one cycle per packet, at or before the cycle of the iSop beat; the block captures each header into a holding register on its valid.
REQ-018 A capture on the same cycle as iSop bypasses the holding register and is used for that packet's decision.
REQ-019 Header flags (A, B, C seen) clear on every iSop beat after the decision is taken.
REQ-020 Decision at the iSop beat: accept = all three flags set AND (iPromisc OR (A == iMac_addr AND C == iEthertype) OR A == 48'hFFFF_FFFF_FFFF).
REQ-021 States: IDLE, PASS, DROP. IDLE + iSop -> PASS if accept, else DROP.
REQ-022 PASS + iEop -> IDLE; DROP + iEop -> IDLE.
REQ-023 A single beat with both iSop and iEop is a complete one-beat packet and returns to IDLE.
REQ-024 Beats with iPayload_valid in IDLE without iSop are discarded and not counted.
REQ-025 iSop in PASS or DROP takes a new decision on that beat, as in IDLE.
REQ-026 If the truncated packet was in PASS, oAbort is asserted with that new beat's output cycle and oDrop_count increments.
REQ-027 Forwarded beats appear exactly 1 cycle after input, registered; data, sop, eop and byte_enable are unchanged.
REQ-028 Non-forwarded cycles drive oPayload_valid = 0.
REQ-029 oSop, oEop, oAbort, oPayload and oByte_enable are 0 whenever oPayload_valid = 0.
REQ-030 oPass_count increments on the cycle after an accepted iEop; oDrop_count increments on the cycle after a rejected iSop.
REQ-031 Both counters saturate at all ones.
REQ-032 There is no backpressure; the block accepts one beat per cycle at all times.
REQ-033 iMac_addr, iEthertype and iPromisc are sampled only at iSop, so a change mid-packet has no effect until the next packet.

Reset
REQ-034 While iReset = 1 at a clock edge: state -> IDLE, header flags and holding registers -> 0, all outputs -> 0, counters -> 0.
REQ-035 Inputs presented during reset are ignored.
REQ-036 A packet in flight when reset asserts is dropped silently, with no oEop and no count.
REQ-037 The first cycle after reset deasserts accepts a new iSop.

Configuration
REQ-038 Macro HEADER_FILTER_STATS_EN defined: oPass_count and oDrop_count behave per REQ-030 and REQ-031.
REQ-039 Macro HEADER_FILTER_STATS_EN undefined: both counters tie to 0 and no counter registers are synthesised; all other behaviour is identical.

Verification
REQ-040 Matching packet: A=iMac_addr=0x0011_2233_4455, C=iEthertype=0x0800, 5 beats -> 5 identical beats out 1 cycle later, oSop on beat 1, oEop on beat 5, oPass_count=1.
REQ-041 Mismatched ethertype: C=0x86DD with iEthertype=0x0800, iPromisc=0 -> no output beats, oDrop_count=1; with iPromisc=1 the same packet is forwarded and oPass_count=1.
REQ-042 Broadcast and missing header: A=0xFFFF_FFFF_FFFF -> forwarded; a packet whose iHeader_C_valid never pulses -> dropped, oDrop_count=1.
REQ-043 Truncation: accepted packet, iSop of a second matching packet on beat 3 with no iEop -> output beat 3 has oSop=1 and oAbort=1, oDrop_count=1, second packet forwarded fully.
REQ-044 Reset mid-packet: iReset=1 for 1 cycle during beat 2 of 5 of an accepted packet -> oPayload_valid=0 for the remaining beats and counters=0; the next packet is forwarded normally.
REQ-045 Back-to-back: 100 random 5-beat packets with no idle cycles, half matching -> 50 packets out in order, oPass_count=50 and oDrop_count=50 with the stats macro, both 0 without it.
